// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO for any depth >= 2 with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count, sticky errors and flush.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_accept, rd_accept;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_comb begin
        wr_accept   = wr_en && !full && !flush;
        rd_accept   = rd_en && !empty && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign dout       = mem_q[rd_ptr_q];
        assign dout_valid = !empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dout_valid_q, dout_valid_d;

        always_comb begin
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
            if (flush) begin
                dout_d = '0;
            end else if (rd_accept) begin
                dout_d       = mem_q[rd_ptr_q];
                dout_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= dout_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: three configurations (16-deep registered, 5-deep registered,
// 5-deep FWFT), each checked against a queue model plus a dout scoreboard monitor.
module tb_sync_fifo_flex;
    logic clk = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    int   done_cnt   = 0;

    always #5 clk = ~clk;

    task automatic check(input int cfg, input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL cfg%0d %s: got %0d, expected %0d at %0t", cfg, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int CFG = g;
        localparam int D   = (g == 0) ? 16 : 5;
        localparam int FW  = (g == 2) ? 1 : 0;
        localparam int AF  = (g == 0) ? 14 : 4;
        localparam int AE  = (g == 0) ? 2 : 1;
        localparam int CW  = $clog2(D + 1);

        logic          rst, flush, wr_en, rd_en;
        logic [7:0]    din, dout;
        logic          dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
        logic [CW-1:0] count;

        logic [7:0] model_q[$];
        logic [7:0] exp_q[$];
        bit         m_ovf, m_udf, m_dv;
        logic [7:0] m_dout;

        sync_fifo_flex #(
            .DATA_WIDTH(8), .DEPTH(D), .FWFT(FW), .AF_THRESH(AF), .AE_THRESH(AE)
        ) u_dut (
            .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
            .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
            .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
            .overflow(overflow), .underflow(underflow)
        );

        task automatic model_reset();
            model_q.delete();
            exp_q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_dv   = 1'b0;
            m_dout = 8'h00;
        endtask

        task automatic check_output();
            int sz;
            sz = model_q.size();
            check(CFG, "count", int'(count), sz);
            check(CFG, "full", int'(full), int'(sz == D));
            check(CFG, "empty", int'(empty), int'(sz == 0));
            check(CFG, "almost_full", int'(almost_full), int'(sz >= AF));
            check(CFG, "almost_empty", int'(almost_empty), int'(sz <= AE));
            check(CFG, "overflow", int'(overflow), int'(m_ovf));
            check(CFG, "underflow", int'(underflow), int'(m_udf));
            check(CFG, "dout_valid", int'(dout_valid), (FW != 0) ? int'(sz > 0) : int'(m_dv));
            if (FW == 0 || sz > 0) begin
                check(CFG, "dout", int'(dout), (FW != 0) ? int'(model_q[0]) : int'(m_dout));
            end
        endtask

        // One clock of stimulus; the model applies the FIFO rules to the pre-edge occupancy.
        task automatic apply_stimulus(input bit w, input logic [7:0] d, input bit r, input bit f);
            int sz;
            wr_en = w;
            din   = d;
            rd_en = r;
            flush = f;
            @(posedge clk);
            sz   = model_q.size();
            m_dv = 1'b0;
            if (f) begin
                model_q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
                if (FW == 0) m_dout = 8'h00;
                else exp_q.delete();
            end else begin
                if (w && sz == D) m_ovf = 1'b1;
                if (r && sz == 0) m_udf = 1'b1;
                if (r && sz > 0) begin
                    m_dout = model_q.pop_front();
                    if (FW == 0) begin
                        m_dv = 1'b1;
                        exp_q.push_back(m_dout);
                    end
                end
                if (w && sz < D) begin
                    model_q.push_back(d);
                    if (FW != 0) exp_q.push_back(d);
                end
            end
            #1;
            check_output();
        endtask

        // Scoreboard monitor: compares every presented word against the expected stream.
        always @(negedge clk) begin
            if (!rst && dout_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL cfg%0d scoreboard: dout_valid with dout=%0d, expected no word", CFG, dout);
                end else begin
                    check(CFG, "scoreboard dout", int'(dout), int'(exp_q[0]));
                    if (FW == 0 || (rd_en && !flush)) void'(exp_q.pop_front());
                end
            end
        end

        initial begin
            rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
            model_reset();
            #2;
            check_output();
            @(negedge clk);
            rst = 1'b0;

            for (int i = 0; i < D; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
            apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b0);
            for (int i = 0; i <= D; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
            for (int i = 3; i < D; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
            apply_stimulus(1'b1, 8'h3C, 1'b1, 1'b0);

            apply_stimulus(1'b1, 8'h77, 1'b1, 1'b1);
            apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0);
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);

            for (int i = 0; i < 400; i++) begin
                int wp;
                int rp;
                wp = (i < 200) ? 3 : 1;
                rp = (i < 200) ? 2 : 3;
                apply_stimulus($urandom_range(3) < wp, 8'($urandom),
                               $urandom_range(3) < rp, $urandom_range(40) == 0);
            end

            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
            for (int i = 0; i < ((D < 9) ? D : 9); i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
            #1;
            rst = 1'b1;
            #1;
            model_reset();
            check_output();
            @(negedge clk);
            rst = 1'b0;
            apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b0);
            apply_stimulus(1'b1, 8'hC3, 1'b1, 1'b0);
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && done_cnt < 3; t++) @(posedge clk);
        if (done_cnt < 3) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout: %0d of 3 configurations finished, expected 3", done_cnt);
        end
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
